// File: rtl/onchip_mem_stream_reader_if.sv
// Memory-side and stream-side signals of the on-chip memory stream reader.
// The reader drives the RAM address/select and the output stream (master).
interface onchip_mem_stream_reader_if;
  logic [12:0] mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic [15:0] mem_readdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem_address, mem_chipselect, mem_clken, out_data, out_valid,
    input  mem_readdata, out_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_clken, out_data, out_valid,
    output mem_readdata, out_ready
  );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// Streams a contiguous (wrapping) block of words out of a single-port RAM
// through a small output FIFO, with abort and one-cycle done pulse.
module onchip_mem_stream_reader #(
  parameter int MEM_WORDS  = 8000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] base_addr,
  input  logic [13:0] length,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  onchip_mem_stream_reader_if.master bus
);

  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [13:0] WORDS_L   = 14'(MEM_WORDS);
  localparam logic [12:0] LAST_ADDR = 13'(MEM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic [12:0] addr_q, addr_next, issue_addr, start_addr;
  logic [13:0] remaining_q, remaining_next, eff_len;
  logic        inflight_q;
  logic        accept, issue, flush, push, pop, room;

  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] fifo_count;

  // The first read is issued in the accepting cycle so data reaches the
  // stream two cycles after start.
  assign accept     = (state == IDLE) && start && !reset;
  assign start_addr = ({1'b0, base_addr} >= WORDS_L) ? '0 : base_addr;
  assign eff_len    = (length > WORDS_L) ? WORDS_L : length;
  assign flush      = abort && ((state == RUN) || (state == DRAIN));
  assign pop        = bus.out_valid && bus.out_ready;
  assign push       = inflight_q && !flush;
  assign room       = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;

  assign bus.out_valid      = (fifo_count != '0);
  assign bus.out_data       = fifo_mem[rd_ptr];
  assign bus.mem_clken      = 1'b1;
  assign bus.mem_address    = issue_addr;
  assign bus.mem_chipselect = issue;

  always_comb begin
    state_next     = state;
    issue          = 1'b0;
    issue_addr     = addr_q;
    addr_next      = addr_q;
    remaining_next = remaining_q;
    done           = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          if (eff_len == 14'd0) begin
            state_next = DONE;
          end else begin
            issue          = 1'b1;
            issue_addr     = start_addr;
            remaining_next = eff_len - 14'd1;
            state_next     = (eff_len == 14'd1) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_next = DONE;
        end else if (room) begin
          issue          = 1'b1;
          remaining_next = remaining_q - 14'd1;
          if (remaining_q == 14'd1) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as the last word is popped so done follows it directly.
        if (flush) begin
          state_next = DONE;
        end else if (!inflight_q &&
                     ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (issue) addr_next = (issue_addr == LAST_ADDR) ? '0 : issue_addr + 13'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state       <= state_next;
      addr_q      <= addr_next;
      remaining_q <= remaining_next;
      inflight_q  <= issue;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_readdata;
  end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Self-checking bench: a queue-based model of the expected address and word
// stream is compared against the reader every cycle.
module tb_onchip_mem_stream_reader;
  localparam int MEM_WORDS  = 8000;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [12:0] base_addr = '0;
  logic [13:0] length = '0;
  logic        busy, done;

  onchip_mem_stream_reader_if bus();

  onchip_mem_stream_reader #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] ram_key = '0;
  logic [12:0] exp_addr[$];
  logic [15:0] exp_data[$];
  logic [12:0] seen_addr[$];
  logic [15:0] seen_data[$];
  int issued_cnt = 0;
  int popped_cnt = 0;
  bit checking = 0;
  bit aborting = 0;
  bit prev_stall = 0;
  logic [15:0] prev_data = '0;
  int start_cyc, first_valid_cyc, last_pop_cyc, done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ram_word(input logic [12:0] a);
    return {3'b000, a} ^ ram_key;
  endfunction

  // RAM model: registered read, junk when not selected.
  always @(posedge clk) begin
    if (bus.mem_chipselect) bus.mem_readdata <= ram_word(bus.mem_address);
    else                    bus.mem_readdata <= 16'hDEAD;
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ((k / 3) % 2) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  // Cycle-by-cycle comparison against the expected address/word queues.
  always @(negedge clk) begin
    if (checking && !reset) begin
      if (bus.mem_chipselect) begin
        seen_addr.push_back(bus.mem_address);
        issued_cnt++;
        if (exp_addr.size() == 0) check_output("unexpected_read", 1, 0);
        else check_output("read_address", bus.mem_address, exp_addr.pop_front());
      end
      if (!aborting) begin
        if (prev_stall) begin
          check_output("stall_valid_hold", bus.out_valid, 1);
          check_output("stall_data_hold", bus.out_data, prev_data);
        end
        if (bus.out_valid) begin
          if (exp_data.size() == 0) check_output("unexpected_word", 1, 0);
          else begin
            check_output("stream_word", bus.out_data, exp_data[0]);
            if (bus.out_ready) begin
              void'(exp_data.pop_front());
              seen_data.push_back(bus.out_data);
              popped_cnt++;
            end
          end
        end
        check_output("occupancy_bound", (issued_cnt - popped_cnt) <= FIFO_DEPTH, 1);
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
      end else begin
        prev_stall = 0;
      end
    end else begin
      prev_stall = 0;
    end
  end

  task automatic apply_stimulus(input int base, input int len, input int mode,
                                input int abort_after, input bit abort_on_start, input bit no_wait);
    int eff, b, budget;
    bit got_done, aborted, abort_now, abort_prev;
    logic [12:0] a;
    got_done = 0; aborted = 0; abort_now = 0; abort_prev = 0;
    eff = (len > MEM_WORDS) ? MEM_WORDS : len;
    b   = (base >= MEM_WORDS) ? 0 : base;
    if (!no_wait) begin @(posedge clk); #1; end
    exp_addr.delete(); exp_data.delete(); seen_addr.delete(); seen_data.delete();
    issued_cnt = 0; popped_cnt = 0;
    for (int i = 0; i < eff; i++) begin
      a = 13'((b + i) % MEM_WORDS);
      exp_addr.push_back(a);
      exp_data.push_back(ram_word(a));
    end
    start = 1'b1; base_addr = 13'(base); length = 14'(len); abort = abort_on_start;
    bus.out_ready = ready_for(mode, 0);
    start_cyc = cyc; first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    @(negedge clk);
    budget = 3 * eff + 20;
    for (int k = 1; k <= budget && !got_done; k++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; abort_now = 0; aborting = 0;
      bus.out_ready = ready_for(mode, k);
      if (abort_after > 0 && !aborted && issued_cnt == abort_after) begin
        abort = 1'b1; bus.out_ready = 1'b0;
        aborted = 1; abort_now = 1; aborting = 1;
        exp_addr.delete(); exp_data.delete(); issued_cnt = 0; popped_cnt = 0;
      end
      @(negedge clk);
      check_output("busy_during_transfer", busy, 1);
      if (abort_now) check_output("abort_stops_issue", bus.mem_chipselect, 0);
      if (abort_prev) begin
        check_output("abort_flush", bus.out_valid, 0);
        check_output("abort_done", done, 1);
      end
      abort_prev = abort_now;
      if (!aborting && bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.out_ready) last_pop_cyc = cyc;
      end
      if (done) begin got_done = 1; done_cyc = cyc; end
    end
    check_output("done_within_budget", got_done, 1);
    if (!aborted) check_output("all_words_delivered", exp_data.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("done_single_pulse", done, 0);
    check_output("idle_after_done", busy, 0);
  endtask

  initial begin
    int b, l, m, ab;
    logic [12:0] wrap_exp [4];
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_out_valid", bus.out_valid, 0);
    check_output("reset_chipselect", bus.mem_chipselect, 0);
    check_output("reset_address", bus.mem_address, 0);
    check_output("reset_clken", bus.mem_clken, 1);
    reset = 1'b0;
    checking = 1;

    $display("[TB] basic burst base=10 length=5");
    apply_stimulus(10, 5, 0, -1, 0, 0);
    check_output("first_valid_latency", first_valid_cyc - start_cyc, 2);
    check_output("done_after_last", done_cyc - last_pop_cyc, 1);
    check_output("burst_span", last_pop_cyc - first_valid_cyc, 4);
    check_output("burst_count", seen_data.size(), 5);
    if (seen_data.size() == 5) begin
      for (int i = 0; i < 5; i++) check_output("burst_word", seen_data[i], 10 + i);
    end

    $display("[TB] address wrap base=7998 length=4");
    apply_stimulus(7998, 4, 0, -1, 0, 0);
    wrap_exp[0] = 13'd7998; wrap_exp[1] = 13'd7999; wrap_exp[2] = 13'd0; wrap_exp[3] = 13'd1;
    check_output("wrap_count", seen_addr.size(), 4);
    if (seen_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) check_output("wrap_address", seen_addr[i], wrap_exp[i]);
    end

    $display("[TB] stalled stream length=100");
    apply_stimulus(300, 100, 1, -1, 0, 0);
    check_output("stall_count", seen_data.size(), 100);
    if (seen_data.size() == 100) check_output("stall_last_word", seen_data[99], 399);

    $display("[TB] zero length");
    apply_stimulus(5, 0, 0, -1, 0, 0);
    check_output("zero_done_latency", done_cyc - start_cyc, 1);
    check_output("zero_no_reads", seen_addr.size(), 0);
    check_output("zero_no_valid", first_valid_cyc, -1);

    $display("[TB] abort after 5 reads");
    apply_stimulus(50, 20, 0, 5, 0, 0);
    check_output("abort_read_count", seen_addr.size(), 5);
    apply_stimulus(200, 3, 0, -1, 0, 0);
    check_output("post_abort_count", seen_data.size(), 3);
    if (seen_data.size() == 3) check_output("post_abort_first", seen_data[0], 200);

    $display("[TB] abort together with start");
    apply_stimulus(40, 3, 0, -1, 1, 0);
    check_output("start_beats_abort", seen_data.size(), 3);

    $display("[TB] base beyond memory");
    apply_stimulus(8100, 2, 0, -1, 0, 0);
    check_output("oob_count", seen_addr.size(), 2);
    if (seen_addr.size() == 2) check_output("oob_first_addr", seen_addr[0], 0);

    $display("[TB] reset mid transfer");
    @(posedge clk); #1;
    exp_addr.delete(); exp_data.delete(); issued_cnt = 0; popped_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      exp_addr.push_back(13'(100 + i));
      exp_data.push_back(ram_word(13'(100 + i)));
    end
    start = 1'b1; base_addr = 13'd100; length = 14'd50; bus.out_ready = 1'b1;
    repeat (8) begin @(posedge clk); #1; start = 1'b0; end
    checking = 0;
    reset = 1'b1;
    #1;
    check_output("midrun_reset_busy", busy, 0);
    check_output("midrun_reset_done", done, 0);
    check_output("midrun_reset_valid", bus.out_valid, 0);
    check_output("midrun_reset_chipselect", bus.mem_chipselect, 0);
    check_output("midrun_reset_address", bus.mem_address, 0);
    check_output("midrun_reset_clken", bus.mem_clken, 1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    checking = 1;
    apply_stimulus(0, 3, 0, -1, 0, 1);
    check_output("after_reset_count", seen_data.size(), 3);
    if (seen_data.size() == 3) begin
      for (int i = 0; i < 3; i++) check_output("after_reset_word", seen_data[i], i);
    end

    $display("[TB] length clipped to memory size");
    apply_stimulus(7990, 8005, 0, -1, 0, 0);
    check_output("clip_count", seen_addr.size(), MEM_WORDS);
    if (seen_data.size() > 10) check_output("clip_wrap_word", seen_data[10], 0);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 15; t++) begin
      ram_key = 16'($urandom);
      b  = $urandom_range(0, 8191);
      l  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60);
      m  = $urandom_range(0, 2);
      ab = (l > 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, l - 1) : -1;
      apply_stimulus(b, l, m, ab, 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onchip_mem_stream_reader.md
ONCHIP_MEM_STREAM_READER -- requirements
Module: onchip_mem_stream_reader

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 8000, number of 16-bit words in the attached single-port RAM.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a transfer, sampled in IDLE only.
REQ-006 SHALL have port base_addr  input  13  first word address, sampled with start.
REQ-007 SHALL have port length  input  14  word count, sampled with start.
REQ-008 SHALL have port abort  input  1  stop the transfer and flush the buffer.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transfer end.
REQ-011 SHALL have port mem_address  output  13  RAM word address.
REQ-012 SHALL have port mem_chipselect  output  1  RAM select, high on read-issue cycles.
REQ-013 SHALL have port mem_clken  output  1  RAM clock enable, tied high.
REQ-014 SHALL have port mem_readdata  input  16  RAM read data, valid exactly one cycle after address issue.
REQ-015 SHALL have port out_data  output  16  stream word.
REQ-016 SHALL have port out_valid  output  1  out_data valid.
REQ-017 SHALL have port out_ready  input  1  downstream accepts when high with out_valid.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL latch base_addr, effective length, go RUN; start outside IDLE SHALL be ignored.
REQ-020 Effective length SHALL be min(length, MEM_WORDS); length=0 SHALL go IDLE->DONE with no read issued.
REQ-021 RUN: a read SHALL issue (mem_chipselect=1, mem_address=current addr) only when fifo_count + inflight < FIFO_DEPTH and words remain.
REQ-022 Each issued read SHALL return one word into the FIFO on the following cycle; inflight is 0 or 1.
REQ-023 Address SHALL increment by 1 per issued read, wrapping from MEM_WORDS-1 to 0.
REQ-024 base_addr >= MEM_WORDS SHALL be reduced to base_addr - MEM_WORDS? No: SHALL be treated as 0.
REQ-025 RUN SHALL go DRAIN on the cycle the last read issues.
REQ-026 DRAIN SHALL go DONE when inflight=0 and FIFO empty.
REQ-027 DONE SHALL assert done for exactly one cycle, then IDLE; busy=0 in IDLE only.
REQ-028 out_valid SHALL equal FIFO non-empty; out_data SHALL be FIFO head; pop on out_valid&out_ready.
REQ-029 FIFO SHALL accept push and pop in the same cycle, including full and empty-with-bypass-free (data appears one cycle after push).
REQ-030 FIFO SHALL never overflow; words SHALL leave in address order with no loss or duplication.
REQ-031 out_valid SHALL not drop while out_ready=0 and FIFO non-empty; out_data SHALL hold stable.
REQ-032 abort in RUN or DRAIN SHALL stop issue immediately, discard the inflight word, clear FIFO next cycle, go DONE.
REQ-033 abort in IDLE or DONE SHALL have no effect; abort and start in same IDLE cycle: start wins.
REQ-034 Sustained throughput with out_ready=1 SHALL be one word per cycle after 2-cycle initial latency (start to first out_valid).

Reset
REQ-035 reset SHALL asynchronously force IDLE, busy=0, done=0, out_valid=0, mem_chipselect=0, mem_address=0, FIFO empty, inflight=0.
REQ-036 reset mid-transfer SHALL discard all state; the first cycle after release SHALL accept start.
REQ-037 mem_clken SHALL be 1 regardless of reset.

Verification
REQ-038 start, base_addr=10, length=5, out_ready=1, RAM[i]=i -> out_data 10..14 on consecutive cycles, first out_valid 2 cycles after start, done 1 cycle after last transfer.
REQ-039 base_addr=7998, length=4 -> addresses 7998,7999,0,1; data in that order.
REQ-040 length=100, out_ready toggling 1/0 every 3 cycles -> 100 words in order, fifo_count never > 4, out_data stable while stalled.
REQ-041 length=0 -> done pulse 1 cycle after start, no chipselect, no out_valid.
REQ-042 length=20, abort at 6th issued read with out_ready=0 -> chipselect stops same cycle, out_valid=0 next cycle, done pulses, next start accepted.
REQ-043 reset asserted mid-RUN of length=50 -> all outputs at reset values immediately; new start base_addr=0 length=3 after release -> words 0,1,2.
